// File: rtl/fp_pkg.sv
// Shared fixed-point helpers: precise-format sizing and rounding/saturation mode encodings.
// Used by the adder, subtractor and multiplier stages of the filter datapath.
package fp_pkg;

    typedef enum int {
        ROUND_TRUNC   = 0,
        ROUND_HALF_UP = 1
    } round_e;

    typedef enum int {
        SAT_WRAP  = 0,
        SAT_CLAMP = 1
    } sat_e;

    function automatic int fp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One extra integer bit keeps a sum or difference of the two inputs exact.
    function automatic int fp_wip(input int wi1, input int wi2);
        return fp_max(wi1, wi2) + 1;
    endfunction

    function automatic int fp_wfp(input int wf1, input int wf2);
        return fp_max(wf1, wf2);
    endfunction

endpackage

// File: rtl/fp_requant.sv
// Re-quantise a signed WIP.WFP value to WIO.WFO with optional round-half-up and saturation.
// Purely combinational; no handshake.
// Not applicable: no backpressure, output follows d.
module fp_requant
    import fp_pkg::*;
#(
    parameter int WIP   = 5,
    parameter int WFP   = 4,
    parameter int WIO   = 5,
    parameter int WFO   = 4,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic signed [WIP+WFP-1:0] d,
    output logic        [WIO+WFO-1:0] q,
    output logic                      ovf
);

    localparam int WD = WIP + WFP;
    localparam int WO = WIO + WFO;
    // Fraction-aligned value keeps all integer bits plus one for a rounding carry.
    localparam int WX = WIP + WFO + 1;

    logic signed [WX-1:0] x;

    generate
        if (WFO >= WFP) begin : g_pad
            assign x = WX'(d) <<< (WFO - WFP);
        end else begin : g_drop
            localparam int SH = WFP - WFO;
            localparam logic signed [WD:0] RND =
                (ROUND == int'(ROUND_HALF_UP)) ? ((WD+1)'(1) <<< (SH - 1)) : '0;
            // Arithmetic shift gives floor; the widened add never loses the carry.
            assign x = WX'(((WD+1)'(d) + RND) >>> SH);
        end

        if (WX <= WO) begin : g_fit
            assign q   = WO'(x);
            assign ovf = 1'b0;
        end else begin : g_chk
            logic [WX-WO:0] hi;
            logic           fits;

            assign hi   = x[WX-1:WO-1];
            assign fits = (hi == '0) || (hi == '1);
            assign ovf  = !fits;

            always_comb begin
                q = x[WO-1:0];
                if (!fits && (SAT == int'(SAT_CLAMP))) begin
                    q = x[WX-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fp_subtractor_pipe.sv
// Pipelined signed fixed-point subtractor out = in1 - in2 with re-quantisation and overflow flags.
// Latency 2 cycles, 1 sample/cycle.
// in_ready = !s1_valid | stage 2 loads, so a stalled out_ready fills both stages then blocks input.
module fp_subtractor_pipe
    import fp_pkg::*;
#(
    parameter int WI1   = 4,
    parameter int WF1   = 4,
    parameter int WI2   = 4,
    parameter int WF2   = 4,
    parameter int WIO   = 5,
    parameter int WFO   = 4,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WI1+WF1-1:0]   in1,
    input  logic [WI2+WF2-1:0]   in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIO+WFO-1:0]   out,
    output logic                 OVF,
    output logic                 OVF_STICKY,
    input  logic                 CLR_STICKY
);

    localparam int WIP = fp_wip(WI1, WI2);
    localparam int WFP = fp_wfp(WF1, WF2);
    localparam int WD  = WIP + WFP;
    localparam int WO  = WIO + WFO;

    logic signed [WD-1:0] a1;
    logic signed [WD-1:0] a2;
    logic signed [WD-1:0] s1_d;
    logic                 s1_valid;
    logic                 s1_load;
    logic                 s2_load;
    logic [WO-1:0]        rq_q;
    logic                 rq_ovf;

    // Align both operands to the common precise format before subtracting.
    assign a1 = WD'($signed(in1)) <<< (WFP - WF1);
    assign a2 = WD'($signed(in2)) <<< (WFP - WF2);

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_d <= a1 - a2;
            end
        end
    end

    fp_requant #(
        .WIP   (WIP),
        .WFP   (WFP),
        .WIO   (WIO),
        .WFO   (WFO),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_requant (
        .d   (s1_d),
        .q   (rq_q),
        .ovf (rq_ovf)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid <= 1'b0;
            out       <= '0;
            OVF       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out <= rq_q;
                OVF <= rq_ovf;
            end
        end
    end

    // A flagged transfer in the same cycle as a clear keeps the flag set.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OVF_STICKY <= 1'b0;
        end else if (out_valid && out_ready && OVF) begin
            OVF_STICKY <= 1'b1;
        end else if (CLR_STICKY) begin
            OVF_STICKY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_subtractor_pipe.sv
// Bench for fp_subtractor_pipe: directed format/rounding/overflow cases on several parameterisations,
// plus stalled and random-handshake streams scored against an arithmetic reference.
module tb_fp_subtractor_pipe;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET_N, in_valid, out_ready, CLR_STICKY;
    logic [7:0] in1, in2, in1m;
    logic [6:0] in2m;

    logic       m_rdy, m_vld, m_ovf, m_stk;  logic [8:0]  m_out;
    logic       s_rdy, s_vld, s_ovf, s_stk;  logic [7:0]  s_out;
    logic       w_rdy, w_vld, w_ovf, w_stk;  logic [7:0]  w_out;
    logic       t_rdy, t_vld, t_ovf, t_stk;  logic [6:0]  t_out;
    logic       r_rdy, r_vld, r_ovf, r_stk;  logic [6:0]  r_out;
    logic       x_rdy, x_vld, x_ovf, x_stk;  logic [10:0] x_out;

    fp_subtractor_pipe u_main (
        .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(m_rdy), .in1(in1), .in2(in2),
        .out_valid(m_vld), .out_ready(out_ready), .out(m_out), .OVF(m_ovf), .OVF_STICKY(m_stk),
        .CLR_STICKY(CLR_STICKY));

    fp_subtractor_pipe #(.WIO(4), .SAT(1)) u_w4sat (
        .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(s_rdy), .in1(in1), .in2(in2),
        .out_valid(s_vld), .out_ready(out_ready), .out(s_out), .OVF(s_ovf), .OVF_STICKY(s_stk),
        .CLR_STICKY(CLR_STICKY));

    fp_subtractor_pipe #(.WIO(4), .SAT(0)) u_w4wrap (
        .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(w_rdy), .in1(in1), .in2(in2),
        .out_valid(w_vld), .out_ready(out_ready), .out(w_out), .OVF(w_ovf), .OVF_STICKY(w_stk),
        .CLR_STICKY(CLR_STICKY));

    fp_subtractor_pipe #(.WFO(2), .ROUND(0)) u_trunc (
        .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(t_rdy), .in1(in1), .in2(in2),
        .out_valid(t_vld), .out_ready(out_ready), .out(t_out), .OVF(t_ovf), .OVF_STICKY(t_stk),
        .CLR_STICKY(CLR_STICKY));

    fp_subtractor_pipe #(.WFO(2), .ROUND(1)) u_round (
        .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(r_rdy), .in1(in1), .in2(in2),
        .out_valid(r_vld), .out_ready(out_ready), .out(r_out), .OVF(r_ovf), .OVF_STICKY(r_stk),
        .CLR_STICKY(CLR_STICKY));

    fp_subtractor_pipe #(.WI1(3), .WF1(5), .WI2(5), .WF2(2), .WIO(6), .WFO(5)) u_mixed (
        .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(x_rdy), .in1(in1m), .in2(in2m),
        .out_valid(x_vld), .out_ready(out_ready), .out(x_out), .OVF(x_ovf), .OVF_STICKY(x_stk),
        .CLR_STICKY(CLR_STICKY));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] am;
        logic [6:0] bm;
    } smp_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: real-valued difference in units of 2^-wfo, floor or half-up, then range limit.
    function automatic logic [31:0] ref_sub(input longint v1, input longint v2,
                                            input int wf1, input int wf2, input int wio,
                                            input int wfo, input int rnd, input int sat,
                                            output bit ovf);
        int     wfp;
        int     wo;
        longint d, r, hi, lo;
        wfp = (wf1 > wf2) ? wf1 : wf2;
        wo  = wio + wfo;
        d   = v1 * (longint'(1) << (wfp - wf1)) - v2 * (longint'(1) << (wfp - wf2));
        if (wfo >= wfp) begin
            r = d * (longint'(1) << (wfo - wfp));
        end else begin
            if (rnd != 0) d = d + (longint'(1) << (wfp - wfo - 1));
            r = d >>> (wfp - wfo);
        end
        hi  = (longint'(1) << (wo - 1)) - 1;
        lo  = -(longint'(1) << (wo - 1));
        ovf = (r > hi) || (r < lo);
        if (ovf && sat != 0) r = (r > hi) ? hi : lo;
        return 32'(r & ((longint'(1) << wo) - 1));
    endfunction

    task automatic check_outputs(input smp_t s);
        logic [31:0] e;
        bit          o;
        e = ref_sub(longint'($signed(s.a)), longint'($signed(s.b)), 4, 4, 5, 4, 0, 1, o);
        chk("main_out", 32'(m_out), e);  chk("main_ovf", 32'(m_ovf), 32'(o));
        e = ref_sub(longint'($signed(s.a)), longint'($signed(s.b)), 4, 4, 4, 4, 0, 1, o);
        chk("sat_out", 32'(s_out), e);   chk("sat_ovf", 32'(s_ovf), 32'(o));
        e = ref_sub(longint'($signed(s.a)), longint'($signed(s.b)), 4, 4, 4, 4, 0, 0, o);
        chk("wrap_out", 32'(w_out), e);  chk("wrap_ovf", 32'(w_ovf), 32'(o));
        e = ref_sub(longint'($signed(s.a)), longint'($signed(s.b)), 4, 4, 5, 2, 0, 1, o);
        chk("trunc_out", 32'(t_out), e); chk("trunc_ovf", 32'(t_ovf), 32'(o));
        e = ref_sub(longint'($signed(s.a)), longint'($signed(s.b)), 4, 4, 5, 2, 1, 1, o);
        chk("round_out", 32'(r_out), e); chk("round_ovf", 32'(r_ovf), 32'(o));
        e = ref_sub(longint'($signed(s.am)), longint'($signed(s.bm)), 5, 2, 6, 5, 0, 1, o);
        chk("mixed_out", 32'(x_out), e); chk("mixed_ovf", 32'(x_ovf), 32'(o));
    endtask

    // One sample into an empty pipe with out_ready=1; returns on the negedge where it is on out.
    task automatic send_pair();
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("lat1_vld", 32'(m_vld), 0);
        @(negedge CLK);
        chk("lat2_vld", 32'(m_vld), 1);
    endtask

    task automatic run_stream(input int n, input int budget, input bit rand_hs,
                              input int st_lo, input int st_hi);
        smp_t       q[$];
        smp_t       cur;
        int         sent = 0;
        int         got  = 0;
        bit         held = 0;
        logic [8:0] hv;
        logic       hf;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge CLK);
            if (sent < n && (!rand_hs || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in1  = 8'($urandom);
                in2  = 8'($urandom);
                in1m = 8'($urandom);
                in2m = 7'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rand_hs ? ($urandom_range(0, 2) != 0) : !(c >= st_lo && c <= st_hi);
            #1;
            if (held) begin
                chk("hold_vld", 32'(m_vld), 1);
                chk("hold_out", 32'(m_out), 32'(hv));
                chk("hold_ovf", 32'(m_ovf), 32'(hf));
            end
            if (!rand_hs && c > st_lo && c <= st_hi) chk("stall_in_rdy", 32'(m_rdy), 0);
            held = m_vld && !out_ready;
            hv   = m_out;
            hf   = m_ovf;
            if (m_vld && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(m_out), 32'hFFFF_FFFF);
                end else begin
                    cur = q.pop_front();
                    check_outputs(cur);
                end
                got++;
            end
            if (in_valid && m_rdy) begin
                q.push_back('{in1, in2, in1m, in2m});
                sent++;
            end
            chk("occupancy", 32'(q.size() <= 2), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got, n);
        chk("stream_left", q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0; in_valid = 1'b0; out_ready = 1'b1; CLR_STICKY = 1'b0;
        in1 = '0; in2 = '0; in1m = '0; in2m = '0;
        repeat (2) @(negedge CLK);
        chk("rst_vld", 32'(m_vld), 0);
        chk("rst_out", 32'(m_out), 0);
        chk("rst_ovf", 32'(m_ovf), 0);
        chk("rst_stk", 32'(m_stk), 0);
        RESET_N = 1'b1;
        #1;
        chk("rst_in_rdy", 32'(m_rdy), 1);
        @(negedge CLK);

        // Full-range difference, overflow in a narrower format, mixed input formats.
        in1 = 8'h7F; in2 = 8'h80; in1m = 8'h30; in2m = 7'h02;
        send_pair();
        chk("t1_out", 32'(m_out), 32'h0FF);  chk("t1_ovf", 32'(m_ovf), 0);
        chk("sat_out", 32'(s_out), 32'h7F);  chk("sat_ovf", 32'(s_ovf), 1);
        chk("wrap_out", 32'(w_out), 32'hFF); chk("wrap_ovf", 32'(w_ovf), 1);
        chk("mix_out", 32'(x_out), 32'h020); chk("mix_ovf", 32'(x_ovf), 0);
        @(negedge CLK);
        chk("drain_vld", 32'(m_vld), 0);
        chk("sat_stk", 32'(s_stk), 1);
        chk("wrap_stk", 32'(w_stk), 1);
        chk("main_stk", 32'(m_stk), 0);
        CLR_STICKY = 1'b1;
        @(negedge CLK);
        CLR_STICKY = 1'b0;
        chk("clr_stk", 32'(s_stk), 0);

        send_pair();
        CLR_STICKY = 1'b1;
        @(negedge CLK);
        CLR_STICKY = 1'b0;
        chk("set_wins", 32'(s_stk), 1);

        // Truncate vs round-half-up when two fraction bits are dropped.
        in1 = 8'h13; in2 = 8'h00;
        send_pair();
        chk("trunc_pos", 32'(t_out), 32'h04);
        chk("round_pos", 32'(r_out), 32'h05);
        @(negedge CLK);
        in1 = 8'hED;
        send_pair();
        chk("round_neg", 32'(r_out), 32'h7B);
        chk("trunc_neg", 32'(t_out), 32'h7B);
        @(negedge CLK);

        run_stream(8, 40, 1'b0, 3, 6);
        run_stream(300, 2000, 1'b1, 0, 0);

        // Async reset with both stages occupied.
        @(negedge CLK);
        out_ready = 1'b0; in_valid = 1'b1; in1 = 8'h7F; in2 = 8'h80;
        repeat (2) @(negedge CLK);
        in_valid = 1'b0;
        chk("full_vld", 32'(m_vld), 1);
        chk("full_in_rdy", 32'(m_rdy), 0);
        chk("full_sat_stk", 32'(s_stk), 1);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_vld", 32'(m_vld), 0);
        chk("arst_out", 32'(m_out), 0);
        chk("arst_sat_stk", 32'(s_stk), 0);
        chk("arst_sat_vld", 32'(s_vld), 0);
        @(negedge CLK);
        RESET_N = 1'b1; out_ready = 1'b1;
        in1 = 8'h12; in2 = 8'h34;
        send_pair();
        chk("post_rst_out", 32'(m_out), 32'h1DE);
        chk("post_rst_ovf", 32'(m_ovf), 0);
        @(negedge CLK);
        chk("post_rst_drain", 32'(m_vld), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
